// File: rtl/inst_encoder.sv
// inst_encoder: packs field bundles into 32-bit instruction words
// and queues {word, address, illegal} toward instruction memory.
module inst_encoder #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_dst,
  input  logic [4:0]  in_src1,
  input  logic [4:0]  in_src2,
  input  logic [19:0] in_imm,
  input  logic [19:0] in_offset,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        out_illegal,
  output logic [15:0] illegal_cnt
);

  localparam logic [6:0] OPCODE_ADD      = 7'h01;
  localparam logic [6:0] OPCODE_SUB      = 7'h02;
  localparam logic [6:0] OPCODE_MUL      = 7'h03;
  localparam logic [6:0] OPCODE_MOV      = 7'h04;
  localparam logic [6:0] OPCODE_TLBWRITE = 7'h05;
  localparam logic [6:0] OPCODE_LDB      = 7'h06;
  localparam logic [6:0] OPCODE_LDW      = 7'h07;
  localparam logic [6:0] OPCODE_STB      = 7'h08;
  localparam logic [6:0] OPCODE_STW      = 7'h09;
  localparam logic [6:0] OPCODE_MOVI     = 7'h0A;
  localparam logic [6:0] OPCODE_BEQ      = 7'h0B;

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem_inst [DEPTH];
  logic [31:0] mem_addr [DEPTH];
  logic        mem_ill  [DEPTH];

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [31:0] addr;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic [31:0] enc_word;
  logic        enc_ill;
  logic        off_ok;
  logic        is_alu;
  logic        is_ld;
  logic        is_st;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign in_ready  = !rst && !restart && (!full || pop);
  assign push      = in_valid && in_ready;

  assign out_inst    = out_valid ? mem_inst[rd_ptr[AW-1:0]] : '0;
  assign out_addr    = out_valid ? mem_addr[rd_ptr[AW-1:0]] : '0;
  assign out_illegal = out_valid ? mem_ill[rd_ptr[AW-1:0]]  : 1'b0;

  assign off_ok = (in_offset[19:15] == 5'd0);
  assign is_alu = (in_opcode == OPCODE_ADD) ||
                  (in_opcode == OPCODE_SUB) ||
                  (in_opcode == OPCODE_MUL);
  assign is_ld  = (in_opcode == OPCODE_LDB) ||
                  (in_opcode == OPCODE_LDW);
  assign is_st  = (in_opcode == OPCODE_STB) ||
                  (in_opcode == OPCODE_STW);

  // Field packing by format; any rejected bundle keeps only the opcode.
  always_comb begin
    enc_word = '0;
    enc_ill  = 1'b0;
    unique case (1'b1)
      is_alu:
        enc_word = {in_opcode, in_dst, in_src1,
                    in_src2, 10'd0};
      (in_opcode == OPCODE_MOV):
        enc_word = {in_opcode, in_dst, in_src1, 15'd0};
      (in_opcode == OPCODE_TLBWRITE):
        enc_word = {in_opcode, 5'd0, in_src1,
                    in_src2, 10'd0};
      is_ld: begin
        enc_ill  = !off_ok;
        enc_word = {in_opcode, in_dst, in_src1,
                    in_offset[14:0]};
      end
      is_st: begin
        enc_ill  = !off_ok;
        enc_word = {in_opcode, in_src2, in_src1,
                    in_offset[14:0]};
      end
      (in_opcode == OPCODE_MOVI):
        enc_word = {in_opcode, in_dst, in_imm};
      (in_opcode == OPCODE_BEQ): begin
        enc_ill  = !off_ok;
        enc_word = {in_opcode, in_offset[14:10], in_src1,
                    in_src2, in_offset[9:0]};
      end
      default:
        enc_ill = 1'b1;
    endcase
    if (enc_ill)
      enc_word = {in_opcode, 25'd0};
  end

  // FIFO storage; contents are masked at the outputs while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr[AW-1:0]] <= enc_word;
      mem_addr[wr_ptr[AW-1:0]] <= addr;
      mem_ill[wr_ptr[AW-1:0]]  <= enc_ill;
    end
  end

  // Pointers, address counter; restart flushes and rewinds the address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      addr   <= BASE_ADDR;
    end else if (restart) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      addr   <= BASE_ADDR;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        addr   <= addr + ADDR_STEP;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Saturating count of illegal bundles; survives restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      illegal_cnt <= '0;
    else if (push && enc_ill && illegal_cnt != 16'hFFFF)
      illegal_cnt <= illegal_cnt + 16'd1;
  end

endmodule
